// File: rtl/da_pkg.sv
// -----------------------------------------------------------------------------
// da_pkg
// Shared types and constants for the distributed-arithmetic FIR control path.
//   da_state_t  : sequencer FSM state encoding
//   cnt_width() : width of the bit-slice index for a given sample width
//   STB_*       : bit positions of the per-cycle strobe vector; the accumulator
//                 block decodes the same vector, so keep these stable.
// -----------------------------------------------------------------------------
package da_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } da_state_t;

    function automatic int cnt_width(input int word_width);
        return $clog2(word_width);
    endfunction

    localparam int STB_XWE  = 0;  // parallel load into first subfilter
    localparam int STB_EN   = 1;  // chain shift / ROM enable
    localparam int STB_TS   = 2;  // sign-time (MSB slice)
    localparam int STB_CLR  = 3;  // accumulator preload (SWb)
    localparam int STB_LAST = 4;  // accumulator final add (SWa)
    localparam int STB_W    = 5;

endpackage

// File: rtl/da_bit_counter.sv
// -----------------------------------------------------------------------------
// da_bit_counter
// Bit-slice index counter. Counts 0 .. WORD_WIDTH-1 while enabled; the
// synchronous clear has priority over the enable so the owner can wrap it on
// the terminal count in the same cycle.
// Ports:
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset
//   clr_i    : synchronous clear to 0
//   en_i     : increment enable
//   cnt_o    : current bit-slice index
//   tc_o     : high when cnt_o == WORD_WIDTH-1
// -----------------------------------------------------------------------------
module da_bit_counter
    import da_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             clr_i,
    input  logic                             en_i,
    output logic [cnt_width(WORD_WIDTH)-1:0] cnt_o,
    output logic                             tc_o
);

    localparam int            CW     = cnt_width(WORD_WIDTH);
    localparam logic [CW-1:0] TC_VAL = CW'(WORD_WIDTH - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/da_sequencer.sv
// -----------------------------------------------------------------------------
// da_sequencer
// Control sequencer for the bit-serial DA FIR subfilter chain. Takes one
// parallel sample per valid/ready handshake, loads it into the first subfilter,
// runs word_width bit-slice cycles, then presents out_valid until downstream
// accepts it.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a sample, in_ready=1
//   LOAD  | one cycle: parallel-load strobe x_we, chain enabled
//   SHIFT | word_width cycles, one bit-slice per cycle, bit_cnt 0..ww-1
//   DONE  | result valid, chain frozen; accepts next sample when out_ready
//
// Ports:
//   clk, rst (async, active low)
//   in_valid/in_ready/x_in   : upstream sample handshake
//   x, x_we                  : registered sample and its load strobe
//   en, Ts, acc_clr, acc_last: chain enable and accumulator control strobes
//   bit_cnt                  : current bit-slice index
//   out_valid/out_ready      : downstream result handshake
//   busy                     : high in any state other than IDLE
//
// All strobes are decoded from the registered state and counter, so an async
// reset forces them low immediately without waiting for a clock edge.
// -----------------------------------------------------------------------------
module da_sequencer
    import da_pkg::*;
#(
    parameter int word_width   = 16,
    parameter int filter_order = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [word_width-1:0]            x_in,
    output logic [word_width-1:0]            x,
    output logic                             x_we,
    output logic                             en,
    output logic                             Ts,
    output logic                             acc_clr,
    output logic                             acc_last,
    output logic [cnt_width(word_width)-1:0] bit_cnt,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    if (word_width < 2) begin : g_bad_word_width
        $error("da_sequencer: word_width must be at least 2");
    end
    if (filter_order < 1) begin : g_bad_filter_order
        $error("da_sequencer: filter_order must be at least 1");
    end

    localparam int CW = cnt_width(word_width);

    da_state_t             state_q;
    logic [word_width-1:0] x_q;
    logic [CW-1:0]         cnt;
    logic                  cnt_tc;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic [STB_W-1:0]      stb;

    // Counter runs only in SHIFT and is held at 0 elsewhere, so LOAD always
    // hands SHIFT a zero index and the wrap on the MSB slice is a plain clear.
    assign cnt_en  = (state_q == SHIFT);
    assign cnt_clr = (state_q != SHIFT) || cnt_tc;

    da_bit_counter #(
        .WORD_WIDTH (word_width)
    ) u_bit_counter (
        .clk_i   (clk),
        .rst_n_i (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .cnt_o   (cnt),
        .tc_o    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= x_in;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_tc) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            x_q     <= x_in;
                            state_q <= LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stb = '0;
        case (state_q)
            LOAD: begin
                stb[STB_XWE] = 1'b1;
                stb[STB_EN]  = 1'b1;
            end
            SHIFT: begin
                stb[STB_EN]   = 1'b1;
                stb[STB_CLR]  = (cnt == '0);
                stb[STB_TS]   = cnt_tc;
                stb[STB_LAST] = cnt_tc;
            end
            default: begin
                stb = '0;
            end
        endcase
    end

    // Back-to-back accept out of DONE only when the current result leaves in
    // the same cycle; in_ready stays low throughout reset.
    assign in_ready  = rst && ((state_q == IDLE) ||
                               ((state_q == DONE) && out_ready));
    assign x         = x_q;
    assign x_we      = stb[STB_XWE];
    assign en        = stb[STB_EN];
    assign Ts        = stb[STB_TS];
    assign acc_clr   = stb[STB_CLR];
    assign acc_last  = stb[STB_LAST];
    assign bit_cnt   = cnt;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_da_sequencer.sv
// -----------------------------------------------------------------------------
// tb_da_sequencer
// Directed stimulus with a scoreboard: each sample expected to produce a result
// is queued when issued; the monitor pops and compares on every out_valid &&
// out_ready handshake and checks strobe timing relative to the x_we pulse.
// -----------------------------------------------------------------------------
module tb_da_sequencer;

    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] x_in;
    logic [WW-1:0] x;
    logic          x_we, en, Ts, acc_clr, acc_last;
    logic [3:0]    bit_cnt;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    da_sequencer #(
        .word_width   (WW),
        .filter_order (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .x         (x),
        .x_we      (x_we),
        .en        (en),
        .Ts        (Ts),
        .acc_clr   (acc_clr),
        .acc_last  (acc_last),
        .bit_cnt   (bit_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [WW-1:0] sb[$];
    int            xwe_log[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor / scoreboard
    int            xwe_cyc = 0;
    int            en_run  = 0;
    logic          ov_prev = 1'b0;
    logic [WW-1:0] exp_x;

    always @(negedge clk) begin
        if (!rst) begin
            ov_prev = 1'b0;
        end else begin
            if (x_we) begin
                xwe_cyc = cyc;
                en_run  = 0;
                xwe_log.push_back(cyc);
                chk("xwe_not_with_ts", Ts, 0);
                chk("xwe_with_en", en, 1);
            end
            if (en) en_run++;
            if (acc_clr) chk("acc_clr_offset", cyc - xwe_cyc, 1);
            if (Ts) begin
                chk("ts_offset", cyc - xwe_cyc, 16);
                chk("ts_bit_cnt", bit_cnt, 15);
                chk("ts_acc_last", acc_last, 1);
            end
            if (out_valid) chk("no_en_in_done", en, 0);
            if (out_valid && !ov_prev) begin
                chk("out_valid_latency", cyc - xwe_cyc, 17);
                chk("en_cycle_count", en_run, 17);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_x = sb.pop_front();
                    chk("result_x", x, exp_x);
                end
            end
            ov_prev = out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [WW-1:0] v, input bit expect_result);
        bit ok = 1'b0;
        in_valid = 1'b1;
        x_in     = v;
        if (expect_result) sb.push_back(v);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    int base;
    int ov_seen;
    bit found;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_reset", in_ready, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_en", en, 0);
        chk("idle_x_we", x_we, 0);
        chk("idle_ts", Ts, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_bit_cnt", bit_cnt, 0);
        chk("idle_busy", busy, 0);
        chk("idle_x", x, 0);
        @(posedge clk);
        #1;

        // Single sample
        send(16'h8001, 1'b1);
        chk("single_x_loaded", x, 16'h8001);
        wait_done();

        // Back-to-back
        base = xwe_log.size();
        send(16'h0001, 1'b1);
        send(16'h7FFF, 1'b1);
        send(16'hFFFF, 1'b1);
        wait_done();
        chk("b2b_xwe_count", xwe_log.size() - base, 3);
        if (xwe_log.size() - base == 3) begin
            chk("b2b_spacing_1", xwe_log[base+1] - xwe_log[base], 18);
            chk("b2b_spacing_2", xwe_log[base+2] - xwe_log[base+1], 18);
        end

        // Backpressure
        out_ready = 1'b0;
        send(16'h5A5A, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        chk("bp_reach_done", found, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid_held", out_valid, 1);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_en_low", en, 0);
            chk("bp_x_stable", x, 16'h5A5A);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_exit_idle_busy", busy, 0);
        chk("bp_exit_out_valid", out_valid, 0);
        chk("bp_exit_in_ready", in_ready, 1);

        // in_valid during SHIFT is ignored
        send(16'hC3C3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        x_in     = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("shift_ignore_x", x, 16'hC3C3);
            chk("shift_ignore_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();

        // Async reset mid-SHIFT at bit_cnt 7
        send(16'h0F0F, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (en && bit_cnt == 4'd7) found = 1'b1;
        end
        chk("rst_reach_cnt7", found, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_x_we", x_we, 0);
        chk("rst_en", en, 0);
        chk("rst_ts", Ts, 0);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_acc_last", acc_last, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_x", x, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        ov_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("aborted_no_out_valid", ov_seen, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/da_sequencer.md
Name: da_sequencer

Overview:
Control sequencer for the bit-serial distributed-arithmetic FIR subfilter chain. Accepts one parallel input sample per handshake and drives the first subfilter's parallel-load write enable (x_we) and the chain's shift enable (en). Generates the sign-time strobe (Ts) for the MSB cycle, plus accumulator control (clear / final-result select). Raises out_valid with backpressure once all word_width bit-slices are processed.

Parameters:
word_width, 16, sample width in bits and number of serial bit-slice cycles per sample
filter_order, 3, taps per subfilter; carried for bookkeeping only, no effect on timing

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  upstream sample available
in_ready  output  1  sequencer can accept a sample this cycle
x_in  input  word_width  upstream two's-complement sample
x  output  word_width  registered sample to subfilter parallel-load port
x_we  output  1  parallel-load strobe to the subfilter shift register
en  output  1  shift/ROM enable for all subfilters
Ts  output  1  sign-time: high only during the MSB bit-slice cycle
acc_clr  output  1  accumulator preload/clear select (SWb), high on bit-slice 0
acc_last  output  1  final-add select (SWa), high on the MSB bit-slice cycle
bit_cnt  output  $clog2(word_width)  current bit-slice index
out_valid  output  1  accumulated result is valid downstream
out_ready  input  1  downstream accepts result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE. x=0; x_we, en, Ts, acc_clr, acc_last, out_valid, busy=0; bit_cnt=0. in_ready=0 while rst=0.
- Reset mid-operation aborts the sample immediately. No output pulse is completed. After release, the FSM is in IDLE.
- FSM states: IDLE, LOAD, SHIFT, DONE. The state is registered, and all outputs are decoded from the registered state and counter (Moore outputs).
- IDLE: in_ready=1. On in_valid&&in_ready: x<=x_in and go to LOAD. Otherwise stay.
- LOAD (1 cycle): x_we=1, en=1. Next state is SHIFT with bit_cnt=0.
- SHIFT (word_width cycles): en=1, bit_cnt increments by 1 each cycle.
  - acc_clr=1 when bit_cnt==0.
  - Ts=1 and acc_last=1 when bit_cnt==word_width-1.
  - On bit_cnt==word_width-1: go to DONE and reset bit_cnt to 0.
- DONE: out_valid=1, en=0. Hold until out_ready=1.
  - in_ready=1 in DONE only when out_ready=1, for a back-to-back accept.
  - On out_ready && in_valid: load x and go to LOAD.
  - On out_ready && !in_valid: go to IDLE.
  - On !out_ready: stay; x and all strobes stay stable.
- Latency: accept at edge N. LOAD occupies cycle N+1. SHIFT occupies N+2 .. N+word_width+1. out_valid rises in cycle N+word_width+2.
- Throughput: one sample per word_width+2 cycles with out_ready held high.
- x_we and Ts are never high in the same cycle. en is never high in IDLE or DONE.
- in_valid=1 while busy (LOAD/SHIFT) is ignored. The upstream holds its data, per valid/ready rules.
- Counter wrap: bit_cnt never exceeds word_width-1. word_width must be ≥2; elaborate-time assertion.
- x holds its last loaded value outside LOAD. It is not cleared on DONE.

Decomposition:
- Shared package da_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} da_state_t.
  - Function cnt_width(word_width) = $clog2(word_width).
  - Constants for the strobe encoding, reused by the future accumulator block.
- One sub-module: da_bit_counter. Async active-low reset, synchronous clear, enable, terminal-count flag at word_width-1. The FSM instantiates it.

Test Plan:
- Reset, then idle with in_valid=0 for 10 cycles -> in_ready=1; en, x_we, Ts, out_valid all 0; bit_cnt=0.
- Single sample x_in=16'h8001, in_valid pulse at cycle 0, out_ready=1 -> x_we=1 at cycle 1; en=1 cycles 1–17; acc_clr at cycle 2; Ts=acc_last=1 at cycle 17 only; out_valid=1 at cycle 18; x==16'h8001.
- Back-to-back, in_valid held high with 3 samples 16'h0001, 16'h7FFF, 16'hFFFF and out_ready=1 -> out_valid pulses every 18 cycles; x_we spacing 18 cycles; no en in DONE cycles.
- Backpressure: out_ready=0 for 5 cycles after DONE entry -> out_valid held 5+ cycles, in_ready=0, en=0, x unchanged. out_ready=1 then exits to IDLE.
- in_valid asserted during SHIFT with different data 16'h1234 -> ignored. x unchanged until the next IDLE/DONE accept.
- rst driven low at bit_cnt=7 in SHIFT, asynchronously mid-cycle -> all outputs 0 before the next clk edge. After release: IDLE, in_ready=1, no out_valid pulse for the aborted sample.
